// File: rtl/imem_responder.sv
// Instruction-side fetch responder: serves IF fetches from a one-entry buffer and
// refills it from the external instruction SRAM over a level req / one-cycle ack port.
module imem_responder #(
  parameter int ADDR_W = 18  // must leave iaddr[ADDR_W+1] inside the 32-bit address
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              ice,
  input  logic [31:0]       iaddr,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              stallreq_if,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ack,
  input  logic [31:0]       sram_rdata,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
  logic [31:0]         buf_data_q, buf_data_d;
  logic                buf_valid_q, buf_valid_d;
  logic                sram_req_q, sram_req_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                hit;
  logic [ADDR_W-1:0]   fetch_word;
  logic                unused_iaddr_bits;

  assign fetch_word        = iaddr[ADDR_W+1:2];
  assign unused_iaddr_bits = ^{iaddr[31:ADDR_W+2], iaddr[1:0]};
  assign hit               = buf_valid_q && (buf_tag_q == req_addr_q);

  // SRAM port: sram_req is a level held from issue through the ack cycle inclusive;
  // sram_ack is a one-cycle strobe that completes the read and is only honoured
  // while a read is outstanding (FILL or DRAIN). sram_addr is stable while sram_req=1.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      sram_req_q  <= 1'b0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      sram_req_q  <= sram_req_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    sram_req_d  = sram_req_q;
    sram_addr_d = sram_addr_q;
    inst_valid  = 1'b0;
    stallreq_if = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ice && !flush) begin
          req_addr_d = fetch_word;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        // Stall is decided by the buffer alone so the stall controller sees no loop.
        stallreq_if = !hit;
        if (flush) begin
          state_d = IDLE;
        end else if (hit) begin
          inst_valid = 1'b1;
          if (ice) req_addr_d = fetch_word;
          else     state_d    = IDLE;
        end else begin
          sram_req_d  = 1'b1;
          sram_addr_d = req_addr_q;
          state_d     = FILL;
        end
      end

      FILL: begin
        stallreq_if = 1'b1;
        if (sram_ack) begin
          buf_tag_d   = req_addr_q;
          buf_data_d  = sram_rdata;
          buf_valid_d = 1'b1;
          sram_req_d  = 1'b0;
          state_d     = flush ? IDLE : RESP;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      RESP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          inst_valid = 1'b1;
          if (ice) begin
            req_addr_d = fetch_word;
            state_d    = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        // The read still completes; its data is valid and kept, but nothing is returned.
        stallreq_if = 1'b1;
        if (sram_ack) begin
          buf_tag_d   = req_addr_q;
          buf_data_d  = sram_rdata;
          buf_valid_d = 1'b1;
          sram_req_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign inst        = inst_valid ? buf_data_q : 32'h0;
  assign sram_req    = sram_req_q;
  assign sram_addr   = sram_addr_q;
  assign dbg_state_o = state_q;

endmodule
